// File: rtl/flash_pattern_gen_pkg.sv
// Shared video package: mode enum with active-area lookups, flash FSM states
// and pixel constants used by the flash pattern generator.
package flash_pattern_gen_pkg;

    typedef enum logic [1:0] {
        VM_640X480    = 2'd0,
        VM_800X600    = 2'd1,
        VM_1280X720   = 2'd2,
        VM_1920X1080I = 2'd3
    } VideoMode;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        DARK = 2'd1,
        LIT  = 2'd2
    } FlashState;

    localparam logic [7:0] PIX_WHITE = 8'hFF;
    localparam logic [7:0] PIX_BLACK = 8'h00;

    function automatic logic [12:0] mode_h_active(input VideoMode m);
        case (m)
            VM_640X480:    return 13'd640;
            VM_800X600:    return 13'd800;
            VM_1280X720:   return 13'd1280;
            VM_1920X1080I: return 13'd1920;
            default:       return 13'd640;
        endcase
    endfunction

    // For interlaced modes this is the per-field line count.
    function automatic logic [12:0] mode_v_active(input VideoMode m);
        case (m)
            VM_640X480:    return 13'd480;
            VM_800X600:    return 13'd600;
            VM_1280X720:   return 13'd720;
            VM_1920X1080I: return 13'd540;
            default:       return 13'd480;
        endcase
    endfunction

    function automatic logic mode_interlaced(input VideoMode m);
        return (m == VM_1920X1080I);
    endfunction

endpackage

// File: rtl/flash_pattern_gen_scheduler.sv
// Flash scheduler: WAIT -> DARK -> LIT -> DARK ... advancing once per frame tick.
// lit / first_lit_frame are registered and valid from the tick cycle onward.
import flash_pattern_gen_pkg::*;

module flash_scheduler #(
    parameter int unsigned LIT_FRAMES  = 2,
    parameter int unsigned DARK_FRAMES = 58
) (
    input  logic clock,
    input  logic reset,
    input  logic frame_tick,
    output logic lit,
    output logic first_lit_frame
);

    // A count of 0 behaves like 1; counter is compared against count-1.
    localparam logic [7:0] LIT_LAST  = (LIT_FRAMES  == 0) ? 8'd0 : 8'(LIT_FRAMES  - 1);
    localparam logic [7:0] DARK_LAST = (DARK_FRAMES == 0) ? 8'd0 : 8'(DARK_FRAMES - 1);

    FlashState   fsm;
    logic [7:0]  frame_cnt;

    // Frame-granular state machine with registered lit / first-lit flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm             <= WAIT;
            frame_cnt       <= '0;
            lit             <= 1'b0;
            first_lit_frame <= 1'b0;
        end else if (frame_tick) begin
            case (fsm)
                WAIT: begin
                    fsm             <= DARK;
                    frame_cnt       <= '0;
                    lit             <= 1'b0;
                    first_lit_frame <= 1'b0;
                end
                DARK: begin
                    if (frame_cnt >= DARK_LAST) begin
                        fsm             <= LIT;
                        frame_cnt       <= '0;
                        lit             <= 1'b1;
                        first_lit_frame <= 1'b1;
                    end else begin
                        frame_cnt       <= frame_cnt + 8'd1;
                        lit             <= 1'b0;
                        first_lit_frame <= 1'b0;
                    end
                end
                LIT: begin
                    if (frame_cnt >= LIT_LAST) begin
                        fsm             <= DARK;
                        frame_cnt       <= '0;
                        lit             <= 1'b0;
                    end else begin
                        frame_cnt       <= frame_cnt + 8'd1;
                        lit             <= 1'b1;
                    end
                    first_lit_frame <= 1'b0;
                end
                default: begin
                    fsm             <= WAIT;
                    frame_cnt       <= '0;
                    lit             <= 1'b0;
                    first_lit_frame <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/flash_pattern_gen.sv
// Flash pattern generator: black screen with a centred box flashing white,
// two-stage pipeline aligned with the timing generator's delayed syncs.
// Optional macro TIME_SLEUTH_BORDER_EN adds a 1-pixel white active-area border.
import flash_pattern_gen_pkg::*;

module flash_pattern_gen #(
    parameter int unsigned BOX_W       = 256,
    parameter int unsigned BOX_H       = 256,
    parameter int unsigned LIT_FRAMES  = 2,
    parameter int unsigned DARK_FRAMES = 58
) (
    input  logic        clock,
    input  logic        reset,
    input  VideoMode    videoMode,
    input  logic [11:0] counterX,
    input  logic [11:0] counterY,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        state,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        de,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        flash_active,
    output logic        flash_start
);

    localparam logic [12:0] BOX_W13 = 13'(BOX_W);
    localparam logic [12:0] BOX_H13 = 13'(BOX_H);

    logic [12:0] h_act, v_act, x0, y0, x_end, y_end, cx, cy;
    logic        active0, inbox0, tick0;
    logic        active_s1, inbox_s1, tick_s1;
    logic        lit, first_lit_frame, white;

    // Box geometry follows the current mode; oversize boxes start at 0.
    always_comb begin
        h_act   = mode_h_active(videoMode);
        v_act   = mode_v_active(videoMode);
        cx      = {1'b0, counterX};
        cy      = {1'b0, counterY};
        x0      = (BOX_W13 >= h_act) ? '0 : ((h_act - BOX_W13) >> 1);
        y0      = (BOX_H13 >= v_act) ? '0 : ((v_act - BOX_H13) >> 1);
        x_end   = x0 + BOX_W13;
        y_end   = y0 + BOX_H13;
        active0 = (cx < h_act) && (cy < v_act);
        inbox0  = active0 && (cx >= x0) && (cx < x_end) && (cy >= y0) && (cy < y_end);
        tick0   = (counterX == 12'd0) && (counterY == 12'd0);
    end

    // The scheduler sees the unregistered tick so its registered lit flag
    // lines up with stage 1, i.e. with the tick pixel itself.
    flash_scheduler #(
        .LIT_FRAMES  (LIT_FRAMES),
        .DARK_FRAMES (DARK_FRAMES)
    ) u_sched (
        .clock           (clock),
        .reset           (reset),
        .frame_tick      (tick0),
        .lit             (lit),
        .first_lit_frame (first_lit_frame)
    );

`ifdef TIME_SLEUTH_BORDER_EN
    logic border0, border_s1;

    // Border on first/last active column and line; odd interlaced fields skip it.
    always_comb begin
        border0 = active0
                  && ((cx == 13'd0) || (cx == 13'(h_act - 13'd1))
                      || (cy == 13'd0) || (cy == 13'(v_act - 13'd1)))
                  && !(mode_interlaced(videoMode) && state);
    end

    // Stage 1 border flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) border_s1 <= 1'b0;
        else       border_s1 <= border0;
    end

    assign white = (inbox_s1 && lit) || border_s1;
`else
    logic unused_state;
    assign unused_state = state;
    assign white        = inbox_s1 && lit;
`endif

    // Stage 1: register counter-derived flags, aligned with incoming syncs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_s1 <= 1'b0;
            inbox_s1  <= 1'b0;
            tick_s1   <= 1'b0;
        end else begin
            active_s1 <= active0;
            inbox_s1  <= inbox0;
            tick_s1   <= tick0;
        end
    end

    // Stage 2: registered pixel, data enable, delayed syncs and flash markers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            red          <= PIX_BLACK;
            green        <= PIX_BLACK;
            blue         <= PIX_BLACK;
            de           <= 1'b0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            flash_active <= 1'b0;
            flash_start  <= 1'b0;
        end else begin
            red          <= white ? PIX_WHITE : PIX_BLACK;
            green        <= white ? PIX_WHITE : PIX_BLACK;
            blue         <= white ? PIX_WHITE : PIX_BLACK;
            de           <= active_s1;
            hsync_out    <= hsync;
            vsync_out    <= vsync;
            flash_active <= lit;
            flash_start  <= tick_s1 && first_lit_frame && active_s1;
        end
    end

endmodule

// File: tb/tb_flash_pattern_gen.sv
// Scoreboard bench for flash_pattern_gen in 640x480: sparse directed pixel
// visits per frame plus one full line, with a second oversize-box instance.
import flash_pattern_gen_pkg::*;

module tb_flash_pattern_gen;

    logic        clock = 1'b0;
    logic        reset;
    VideoMode    videoMode;
    logic [11:0] counterX, counterY;
    logic        hsync, vsync, state;
    logic [7:0]  red, green, blue, red_big, green_big, blue_big;
    logic        de, hsync_out, vsync_out, flash_active, flash_start;
    logic        de_big, hs_big, vs_big, fa_big, fs_big;

    always #5 clock = ~clock;

    flash_pattern_gen #(.BOX_W(256), .BOX_H(256), .LIT_FRAMES(2), .DARK_FRAMES(3)) dut (
        .clock(clock), .reset(reset), .videoMode(videoMode),
        .counterX(counterX), .counterY(counterY),
        .hsync(hsync), .vsync(vsync), .state(state),
        .red(red), .green(green), .blue(blue), .de(de),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .flash_active(flash_active), .flash_start(flash_start)
    );

    flash_pattern_gen #(.BOX_W(1024), .BOX_H(256), .LIT_FRAMES(2), .DARK_FRAMES(3)) dut_big (
        .clock(clock), .reset(reset), .videoMode(videoMode),
        .counterX(counterX), .counterY(counterY),
        .hsync(hsync), .vsync(vsync), .state(state),
        .red(red_big), .green(green_big), .blue(blue_big), .de(de_big),
        .hsync_out(hs_big), .vsync_out(vs_big),
        .flash_active(fa_big), .flash_start(fs_big)
    );

    typedef struct {
        int unsigned due;
        logic        de;
        logic [7:0]  pix;
        logic        fa;
        logic        fs;
        logic [7:0]  pix_big;
    } pix_exp_t;

    typedef struct {
        int unsigned due;
        logic        hs;
        logic        vs;
    } sync_exp_t;

    pix_exp_t    pq[$];
    sync_exp_t   sq[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned passes = 0;
    int          frame_idx;
    int          prev_x, prev_y;

    localparam int NPTS = 14;
    int pts_x[NPTS] = '{0, 191, 192, 447, 448, 192, 300, 300, 639, 640, 100,   0, 799, 700};
    int pts_y[NPTS] = '{0, 112, 112, 112, 112, 111, 367, 368, 479, 100, 480, 250, 524, 490};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one counter pair and queue the expected response of both DUTs.
    task automatic drive(input int x, input int y);
        pix_exp_t  e;
        sync_exp_t s;
        logic      lit, first, act, inbox, inbig, hs, vs;
        @(negedge clock);
        hs = (prev_x >= 656) && (prev_x < 752);
        vs = (prev_y >= 490) && (prev_y < 492);
        counterX = 12'(x);
        counterY = 12'(y);
        hsync    = hs;
        vsync    = vs;
        prev_x   = x;
        prev_y   = y;
        if (x == 0 && y == 0) frame_idx++;
        lit   = (frame_idx > 0) && (((frame_idx - 1) % 5) >= 3);
        first = (frame_idx > 0) && (((frame_idx - 1) % 5) == 3);
        act   = (x < 640) && (y < 480);
        inbox = act && (x >= 192) && (x <= 447) && (y >= 112) && (y <= 367);
        inbig = act && (y >= 112) && (y <= 367);
        e.due     = cyc + 2;
        e.de      = act;
        e.pix     = (inbox && lit) ? 8'hFF : 8'h00;
        e.fa      = lit;
        e.fs      = first && (x == 0) && (y == 0);
        e.pix_big = (inbig && lit) ? 8'hFF : 8'h00;
        pq.push_back(e);
        s.due = cyc + 1;
        s.hs  = hs;
        s.vs  = vs;
        sq.push_back(s);
    endtask

    task automatic run_frame();
        for (int i = 0; i < NPTS; i++) drive(pts_x[i], pts_y[i]);
    endtask

    task automatic scan_line(input int y);
        for (int x = 0; x < 800; x++) drive(x, y);
    endtask

    // Monitor: compare every queued expectation on its due cycle.
    always @(posedge clock) begin
        pix_exp_t  e;
        sync_exp_t s;
        #1;
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            chk("de",           int'(de),           int'(e.de));
            chk("red",          int'(red),          int'(e.pix));
            chk("green",        int'(green),        int'(e.pix));
            chk("blue",         int'(blue),         int'(e.pix));
            chk("flash_active", int'(flash_active), int'(e.fa));
            chk("flash_start",  int'(flash_start),  int'(e.fs));
            chk("red_big",      int'(red_big),      int'(e.pix_big));
            chk("de_big",       int'(de_big),       int'(e.de));
        end
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            s = sq.pop_front();
            chk("hsync_out", int'(hsync_out), int'(s.hs));
            chk("vsync_out", int'(vsync_out), int'(s.vs));
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        videoMode = VM_640X480;
        counterX  = 12'd5;
        counterY  = 12'd5;
        hsync     = 1'b1;
        vsync     = 1'b1;
        state     = 1'b0;
        frame_idx = 0;
        prev_x    = 5;
        prev_y    = 5;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_red",       int'(red),          0);
        chk("rst_green",     int'(green),        0);
        chk("rst_blue",      int'(blue),         0);
        chk("rst_de",        int'(de),           0);
        chk("rst_hsync_out", int'(hsync_out),    0);
        chk("rst_vsync_out", int'(vsync_out),    0);
        chk("rst_fa",        int'(flash_active), 0);
        chk("rst_fs",        int'(flash_start),  0);

        @(negedge clock);
        reset = 1'b0;

        // Partial first frame: box pixels stay black.
        drive(300, 200);
        drive(192, 112);
        drive(639, 479);

        for (int fr = 1; fr <= 10; fr++) begin
            run_frame();
            if (fr == 4) scan_line(200);
        end
        for (int fr = 11; fr <= 13; fr++) run_frame();

        // Frame 14 is the first lit frame of the third flash.
        drive(0, 0);
        repeat (3) drive(300, 200);
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("prereset_red", int'(red),          8'hFF);
        chk("prereset_fa",  int'(flash_active), 1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_red", int'(red),          0);
        chk("midrst_fa",  int'(flash_active), 0);
        chk("midrst_de",  int'(de),           0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset     = 1'b0;
        frame_idx = 0;

        // Restart from WAIT: partial frame then D,D,D,L,L.
        drive(300, 200);
        for (int fr = 1; fr <= 5; fr++) run_frame();

        repeat (5) @(posedge clock);
        #2;
        chk("drain_pix",  pq.size(), 0);
        chk("drain_sync", sq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
